// File: rtl/usbf_txn_seq_if.sv
// usbf_txn_seq_if
//   Bundles the signals between the USB packet decoder/endpoint/TX side and
//   the transaction sequencer.
//   master : decoder-side view. It drives token/PID/RX status, endpoint
//            status and tx_done, and it observes the sequencer outputs.
//   slave  : sequencer-side view (usbf_txn_seq).
//   Signals:
//     fa           function address of this device
//     token_*      token strobe, address and endpoint; crc5_err and pid_cks_err
//     pid_*        decoded PID flags
//     rx_*         RX byte strobe, end-of-data strobe and crc16_err
//     ep_stall/rdy status of the selected endpoint
//     ep_sel       endpoint latched for the current transaction
//     data_wr      buffer write strobe
//     data_commit  OUT/SETUP packet accepted
//     in_commit    IN packet ACKed by the host
//     tx_req/kind  packet request to TX, held until tx_done
//     sof_pulse    valid SOF seen
//     to_err       data or ACK phase timed out
//     busy         sequencer not idle
interface usbf_txn_seq_if;
    logic [6:0] fa;
    logic       token_valid;
    logic [6:0] token_fadr;
    logic [3:0] token_endp;
    logic       crc5_err;
    logic       pid_cks_err;
    logic       pid_OUT, pid_IN, pid_SETUP, pid_PING, pid_SOF, pid_ACK, pid_DATA0, pid_DATA1;
    logic       rx_data_valid;
    logic       rx_data_done;
    logic       crc16_err;
    logic       ep_stall;
    logic       ep_rdy;
    logic [3:0] ep_sel;
    logic       data_wr;
    logic       data_commit;
    logic       in_commit;
    logic       tx_req;
    logic [2:0] tx_kind;
    logic       tx_done;
    logic       sof_pulse;
    logic       to_err;
    logic       busy;

    modport master (
        output fa, token_valid, token_fadr, token_endp, crc5_err, pid_cks_err,
               pid_OUT, pid_IN, pid_SETUP, pid_PING, pid_SOF, pid_ACK, pid_DATA0, pid_DATA1,
               rx_data_valid, rx_data_done, crc16_err, ep_stall, ep_rdy, tx_done,
        input  ep_sel, data_wr, data_commit, in_commit, tx_req, tx_kind, sof_pulse, to_err, busy
    );

    modport slave (
        input  fa, token_valid, token_fadr, token_endp, crc5_err, pid_cks_err,
               pid_OUT, pid_IN, pid_SETUP, pid_PING, pid_SOF, pid_ACK, pid_DATA0, pid_DATA1,
               rx_data_valid, rx_data_done, crc16_err, ep_stall, ep_rdy, tx_done,
        output ep_sel, data_wr, data_commit, in_commit, tx_req, tx_kind, sof_pulse, to_err, busy
    );
endinterface

// File: rtl/usbf_txn_seq.sv
// usbf_txn_seq
//   USB function transaction sequencer. It sits behind the packet decoder and
//   does the following:
//   - qualifies tokens against the function address;
//   - tracks the DATA0/1 toggles of each endpoint;
//   - gates RX buffer writes;
//   - requests handshake and data packets from TX;
//   - times out data and ACK phases that never arrive.
//   All outputs are registered, so each appears one cycle after its event.
//   Ports:
//     clk  clock
//     rst  asynchronous active-high reset
//     bus  usbf_txn_seq_if.slave (see interface header for signal list)
//   Parameters:
//     TO_CYC  idle-bus timeout in clk cycles (RX_DATA and WAIT_ACK)
//     TO_W    timeout counter width, TO_CYC < 2**TO_W
module usbf_txn_seq #(
    parameter int TO_CYC = 622,
    parameter int TO_W   = 10
) (
    input  logic          clk,
    input  logic          rst,
    usbf_txn_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RX_DATA, HS_SEND, TX_DATA, WAIT_ACK} state_t;

    localparam logic [2:0] KIND_ACK   = 3'd0;
    localparam logic [2:0] KIND_NAK   = 3'd1;
    localparam logic [2:0] KIND_STALL = 3'd2;

    state_t          state, state_nx;
    logic [3:0]      ep_q, ep_nx;
    logic            is_setup_q, is_setup_nx;
    logic [TO_W-1:0] cnt_q, cnt_nx;
    logic [15:0]     out_tgl_q, out_tgl_nx;
    logic [15:0]     in_tgl_q, in_tgl_nx;
    logic [2:0]      kind_q, kind_nx;
    logic            data_wr_q, data_wr_nx;
    logic            commit_q, commit_nx;
    logic            in_commit_q, in_commit_nx;
    logic            sof_q, sof_nx;
    logic            to_err_q, to_err_nx;

    // Shared qualifiers used by both next-state and datapath logic.
    logic       tok_ok, sof_ok, ack_ok, timeout, data_ok;
    logic [2:0] hs_kind;

    assign tok_ok  = bus.token_valid & ~bus.crc5_err & ~bus.pid_cks_err & (bus.token_fadr == bus.fa);
    assign sof_ok  = bus.token_valid & bus.pid_SOF & ~bus.crc5_err & ~bus.pid_cks_err;
    assign ack_ok  = bus.token_valid & bus.pid_ACK & ~bus.pid_cks_err;
    assign timeout = (cnt_q == TO_W'(TO_CYC - 1));
    // A finished data packet is answered only if its CRC is good and it really was DATA0/1.
    assign data_ok = bus.rx_data_done & ~bus.crc16_err & (bus.pid_DATA0 | bus.pid_DATA1);
    // STALL beats NAK beats ACK for PING and OUT/SETUP handshakes.
    assign hs_kind = bus.ep_stall ? KIND_STALL : (~bus.ep_rdy ? KIND_NAK : KIND_ACK);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ep_q        <= '0;
            is_setup_q  <= 1'b0;
            cnt_q       <= '0;
            // NOTE: the toggle bits are 32 discrete flops and not a RAM, so they take the async reset like any other state.
            out_tgl_q   <= '0;
            in_tgl_q    <= '0;
            kind_q      <= '0;
            data_wr_q   <= 1'b0;
            commit_q    <= 1'b0;
            in_commit_q <= 1'b0;
            sof_q       <= 1'b0;
            to_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignment, so every flop here samples the pre-edge values.
            state       <= state_nx;
            ep_q        <= ep_nx;
            is_setup_q  <= is_setup_nx;
            cnt_q       <= cnt_nx;
            out_tgl_q   <= out_tgl_nx;
            in_tgl_q    <= in_tgl_nx;
            kind_q      <= kind_nx;
            data_wr_q   <= data_wr_nx;
            commit_q    <= commit_nx;
            in_commit_q <= in_commit_nx;
            sof_q       <= sof_nx;
            to_err_q    <= to_err_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: give a default before the case, so that no path leaves the variable unassigned and infers a latch.
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (tok_ok) begin
                    if (bus.pid_OUT | bus.pid_SETUP)
                        state_nx = RX_DATA;
                    else if (bus.pid_IN)
                        state_nx = (bus.ep_stall | ~bus.ep_rdy) ? HS_SEND : TX_DATA;
                    else if (bus.pid_PING)
                        state_nx = HS_SEND;
                end
            end
            // When done and timeout coincide, done wins: it is checked first.
            RX_DATA: begin
                if (bus.rx_data_done)
                    state_nx = data_ok ? HS_SEND : IDLE;
                else if (timeout)
                    state_nx = IDLE;
            end
            HS_SEND:  if (bus.tx_done) state_nx = IDLE;
            TX_DATA:  if (bus.tx_done) state_nx = WAIT_ACK;
            WAIT_ACK: if (bus.token_valid | timeout) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        ep_nx        = ep_q;
        is_setup_nx  = is_setup_q;
        cnt_nx       = '0;
        out_tgl_nx   = out_tgl_q;
        in_tgl_nx    = in_tgl_q;
        kind_nx      = kind_q;
        data_wr_nx   = 1'b0;
        commit_nx    = 1'b0;
        in_commit_nx = 1'b0;
        sof_nx       = sof_ok;
        to_err_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (tok_ok) begin
                    ep_nx       = bus.token_endp;
                    is_setup_nx = bus.pid_SETUP;
                    if (bus.pid_IN)
                        kind_nx = (bus.ep_stall | ~bus.ep_rdy) ? hs_kind
                                                               : {2'b10, in_tgl_q[bus.token_endp]};
                    else if (bus.pid_PING)
                        kind_nx = hs_kind;
                end
            end
            RX_DATA: begin
                data_wr_nx = bus.rx_data_valid & ~bus.ep_stall & bus.ep_rdy;
                cnt_nx     = bus.rx_data_valid ? '0 : cnt_q + 1'b1;
                if (data_ok) begin
                    kind_nx = hs_kind;
                    // A SETUP always expects DATA0. A PID mismatch is a host retry: we ACK it but do not commit it.
                    if (hs_kind == KIND_ACK &&
                        bus.pid_DATA1 == (is_setup_q ? 1'b0 : out_tgl_q[ep_q])) begin
                        commit_nx = 1'b1;
                        if (is_setup_q) begin
                            out_tgl_nx[ep_q] = 1'b1;
                            in_tgl_nx[ep_q]  = 1'b1;
                        end else begin
                            out_tgl_nx[ep_q] = ~out_tgl_q[ep_q];
                        end
                    end
                end else if (!bus.rx_data_done && timeout) begin
                    to_err_nx = 1'b1;
                end
            end
            WAIT_ACK: begin
                cnt_nx = cnt_q + 1'b1;
                if (ack_ok) begin
                    in_commit_nx    = 1'b1;
                    in_tgl_nx[ep_q] = ~in_tgl_q[ep_q];
                end else if (!bus.token_valid && timeout) begin
                    to_err_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ep_sel      = ep_q;
    assign bus.data_wr     = data_wr_q;
    assign bus.data_commit = commit_q;
    assign bus.in_commit   = in_commit_q;
    assign bus.tx_req      = (state == HS_SEND) || (state == TX_DATA);
    assign bus.tx_kind     = kind_q;
    assign bus.sof_pulse   = sof_q;
    assign bus.to_err      = to_err_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_usbf_txn_seq.sv
// tb_usbf_txn_seq
//   Directed bench for usbf_txn_seq with fa=5 and TO_CYC=622. Each task
//   drives one scenario and compares the DUT outputs one cycle after the
//   stimulus edge (#1 after posedge) against values worked out by hand.
module tb_usbf_txn_seq;
    typedef enum {T_OUT, T_IN, T_SETUP, T_PING, T_SOF, T_ACK} tok_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    usbf_txn_seq_if bus();

    usbf_txn_seq #(.TO_CYC(622), .TO_W(10)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_token(input tok_t t, input logic [6:0] fadr, input logic [3:0] endp,
                              input logic crc_bad);
        bus.token_valid = 1'b1;
        bus.token_fadr  = fadr;
        bus.token_endp  = endp;
        bus.crc5_err    = crc_bad;
        bus.pid_OUT     = (t == T_OUT);
        bus.pid_IN      = (t == T_IN);
        bus.pid_SETUP   = (t == T_SETUP);
        bus.pid_PING    = (t == T_PING);
        bus.pid_SOF     = (t == T_SOF);
        bus.pid_ACK     = (t == T_ACK);
        tick();
        bus.token_valid = 1'b0;
        bus.crc5_err    = 1'b0;
        {bus.pid_OUT, bus.pid_IN, bus.pid_SETUP, bus.pid_PING, bus.pid_SOF, bus.pid_ACK} = '0;
    endtask

    // Sends nbytes data bytes and then the done strobe. On return, the
    // outputs reflect the done edge. wr_seen is set if any byte produced data_wr.
    task automatic send_data(input logic d1, input int nbytes, input logic crc_bad,
                             output logic wr_seen);
        bus.pid_DATA0 = ~d1;
        bus.pid_DATA1 = d1;
        wr_seen = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            bus.rx_data_valid = 1'b1;
            tick();
            wr_seen = wr_seen | bus.data_wr;
        end
        bus.rx_data_valid = 1'b0;
        bus.rx_data_done  = 1'b1;
        bus.crc16_err     = crc_bad;
        tick();
        bus.rx_data_done  = 1'b0;
        bus.crc16_err     = 1'b0;
        bus.pid_DATA0     = 1'b0;
        bus.pid_DATA1     = 1'b0;
    endtask

    task automatic tx_finish();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.tx_req !== 1'b0) begin errors++; $display("FAIL rst_tx_req: got %b want 0", bus.tx_req); end
        checks++; if (bus.ep_sel !== 4'd0) begin errors++; $display("FAIL rst_ep_sel: got %0d want 0", bus.ep_sel); end
        checks++; if ({bus.data_wr, bus.data_commit, bus.in_commit, bus.sof_pulse, bus.to_err, bus.tx_kind} !== 8'd0)
            begin errors++; $display("FAIL rst_outputs: got %b want 0", {bus.data_wr, bus.data_commit, bus.in_commit, bus.sof_pulse, bus.to_err, bus.tx_kind}); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_out_toggle();
        logic wr;
        send_token(T_OUT, 7'd5, 4'd2, 1'b0);
        checks++; if (bus.busy !== 1'b1)   begin errors++; $display("FAIL out_busy: got %b want 1", bus.busy); end
        checks++; if (bus.ep_sel !== 4'd2) begin errors++; $display("FAIL out_ep_sel: got %0d want 2", bus.ep_sel); end
        send_data(1'b0, 3, 1'b0, wr);
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL out_data_wr: got %b want 1", wr); end
        checks++; if (bus.tx_req !== 1'b1)      begin errors++; $display("FAIL out_tx_req: got %b want 1", bus.tx_req); end
        checks++; if (bus.tx_kind !== 3'd0)     begin errors++; $display("FAIL out_ack_kind: got %0d want 0", bus.tx_kind); end
        checks++; if (bus.data_commit !== 1'b1) begin errors++; $display("FAIL out_commit: got %b want 1", bus.data_commit); end
        tick();
        checks++; if ({bus.tx_req, bus.data_commit} !== 2'b10)
            begin errors++; $display("FAIL out_req_hold: got %b want 10", {bus.tx_req, bus.data_commit}); end
        tx_finish();
        checks++; if ({bus.busy, bus.tx_req} !== 2'b00)
            begin errors++; $display("FAIL out_done_idle: got %b want 00", {bus.busy, bus.tx_req}); end
        // out_tgl[2] is now 1, so a repeated DATA0 is a retry: it gets an ACK but no commit.
        send_token(T_OUT, 7'd5, 4'd2, 1'b0);
        send_data(1'b0, 2, 1'b0, wr);
        checks++; if ({bus.tx_req, bus.tx_kind, bus.data_commit} !== 5'b1_000_0)
            begin errors++; $display("FAIL out_retry: got %b want 10000", {bus.tx_req, bus.tx_kind, bus.data_commit}); end
        tx_finish();
        send_token(T_OUT, 7'd5, 4'd2, 1'b0);
        send_data(1'b1, 2, 1'b0, wr);
        checks++; if (bus.data_commit !== 1'b1) begin errors++; $display("FAIL out_data1_commit: got %b want 1", bus.data_commit); end
        tx_finish();
    endtask

    task automatic test_setup_in();
        logic wr;
        send_token(T_SETUP, 7'd5, 4'd0, 1'b0);
        send_data(1'b0, 8, 1'b0, wr);
        checks++; if ({bus.tx_kind, bus.data_commit} !== 4'b000_1)
            begin errors++; $display("FAIL setup_ack: got %b want 0001", {bus.tx_kind, bus.data_commit}); end
        tx_finish();
        send_token(T_IN, 7'd5, 4'd0, 1'b0);
        checks++; if ({bus.tx_req, bus.tx_kind} !== 4'b1_101)
            begin errors++; $display("FAIL in_data1: got %b want 1101", {bus.tx_req, bus.tx_kind}); end
        tx_finish();
        checks++; if ({bus.busy, bus.tx_req} !== 2'b10)
            begin errors++; $display("FAIL wait_ack_state: got %b want 10", {bus.busy, bus.tx_req}); end
        send_token(T_ACK, 7'd0, 4'd0, 1'b0);
        checks++; if ({bus.in_commit, bus.busy} !== 2'b10)
            begin errors++; $display("FAIL in_commit: got %b want 10", {bus.in_commit, bus.busy}); end
        send_token(T_IN, 7'd5, 4'd0, 1'b0);
        checks++; if (bus.tx_kind !== 3'd4) begin errors++; $display("FAIL in_toggle_flip: got %0d want 4", bus.tx_kind); end
        tx_finish();
        send_token(T_ACK, 7'd0, 4'd0, 1'b0);
    endtask

    task automatic test_handshakes();
        bus.ep_stall = 1'b1;
        send_token(T_IN, 7'd5, 4'd1, 1'b0);
        checks++; if ({bus.tx_req, bus.tx_kind} !== 4'b1_010)
            begin errors++; $display("FAIL in_stall: got %b want 1010", {bus.tx_req, bus.tx_kind}); end
        tx_finish();
        bus.ep_stall = 1'b0;
        bus.ep_rdy   = 1'b0;
        send_token(T_IN, 7'd5, 4'd1, 1'b0);
        checks++; if ({bus.tx_req, bus.tx_kind} !== 4'b1_001)
            begin errors++; $display("FAIL in_nak: got %b want 1001", {bus.tx_req, bus.tx_kind}); end
        tx_finish();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hs_return_idle: got %b want 0", bus.busy); end
        bus.ep_rdy = 1'b1;
        send_token(T_PING, 7'd5, 4'd1, 1'b0);
        checks++; if ({bus.tx_req, bus.tx_kind} !== 4'b1_000)
            begin errors++; $display("FAIL ping_ack: got %b want 1000", {bus.tx_req, bus.tx_kind}); end
        tx_finish();
        send_token(T_OUT, 7'd6, 4'd1, 1'b0);
        checks++; if ({bus.busy, bus.tx_req} !== 2'b00)
            begin errors++; $display("FAIL wrong_addr: got %b want 00", {bus.busy, bus.tx_req}); end
        send_token(T_IN, 7'd5, 4'd1, 1'b1);
        checks++; if ({bus.busy, bus.tx_req} !== 2'b00)
            begin errors++; $display("FAIL crc5_reject: got %b want 00", {bus.busy, bus.tx_req}); end
    endtask

    task automatic test_crc16_nak();
        logic wr;
        send_token(T_OUT, 7'd5, 4'd4, 1'b0);
        send_data(1'b0, 2, 1'b1, wr);
        checks++; if ({bus.busy, bus.tx_req, bus.data_commit} !== 3'b000)
            begin errors++; $display("FAIL crc16_silent: got %b want 000", {bus.busy, bus.tx_req, bus.data_commit}); end
        bus.ep_rdy = 1'b0;
        send_token(T_OUT, 7'd5, 4'd4, 1'b0);
        send_data(1'b0, 2, 1'b0, wr);
        checks++; if ({wr, bus.tx_kind, bus.data_commit} !== 5'b0_001_0)
            begin errors++; $display("FAIL out_nak: got %b want 00010", {wr, bus.tx_kind, bus.data_commit}); end
        tx_finish();
        bus.ep_rdy = 1'b1;
    endtask

    task automatic test_sof();
        send_token(T_SOF, 7'd9, 4'd3, 1'b0);
        checks++; if ({bus.sof_pulse, bus.busy} !== 2'b10)
            begin errors++; $display("FAIL sof_pulse: got %b want 10", {bus.sof_pulse, bus.busy}); end
        tick();
        checks++; if (bus.sof_pulse !== 1'b0) begin errors++; $display("FAIL sof_width: got %b want 0", bus.sof_pulse); end
    endtask

    task automatic test_timeout_rx();
        int n;
        send_token(T_OUT, 7'd5, 4'd3, 1'b0);
        n = 0;
        while (n < 700 && bus.to_err !== 1'b1) begin
            tick();
            n++;
        end
        checks++; if (n != 622) begin errors++; $display("FAIL rx_timeout_cycles: got %0d want 622", n); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rx_timeout_idle: got %b want 0", bus.busy); end
        tick();
        checks++; if (bus.to_err !== 1'b0) begin errors++; $display("FAIL to_err_width: got %b want 0", bus.to_err); end
    endtask

    task automatic test_timeout_ack();
        int n;
        send_token(T_IN, 7'd5, 4'd6, 1'b0);
        checks++; if (bus.tx_kind !== 3'd4) begin errors++; $display("FAIL ack_to_first_pid: got %0d want 4", bus.tx_kind); end
        tx_finish();
        n = 0;
        while (n < 700 && bus.to_err !== 1'b1) begin
            tick();
            n++;
        end
        checks++; if (n != 622) begin errors++; $display("FAIL ack_timeout_cycles: got %0d want 622", n); end
        send_token(T_IN, 7'd5, 4'd6, 1'b0);
        checks++; if (bus.tx_kind !== 3'd4) begin errors++; $display("FAIL ack_timeout_no_flip: got %0d want 4", bus.tx_kind); end
        tx_finish();
        send_token(T_ACK, 7'd0, 4'd0, 1'b0);
    endtask

    task automatic test_reset_mid_tx();
        logic wr;
        // in_tgl[0] and out_tgl[0] are both 1 after test_setup_in.
        send_token(T_IN, 7'd5, 4'd0, 1'b0);
        checks++; if ({bus.tx_req, bus.tx_kind} !== 4'b1_101)
            begin errors++; $display("FAIL pre_rst_in: got %b want 1101", {bus.tx_req, bus.tx_kind}); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.tx_req, bus.busy} !== 2'b00)
            begin errors++; $display("FAIL rst_async_drop: got %b want 00", {bus.tx_req, bus.busy}); end
        tick();
        rst = 1'b0;
        tick();
        send_token(T_IN, 7'd5, 4'd0, 1'b0);
        checks++; if (bus.tx_kind !== 3'd4) begin errors++; $display("FAIL rst_in_tgl: got %0d want 4", bus.tx_kind); end
        tx_finish();
        send_token(T_ACK, 7'd0, 4'd0, 1'b0);
        send_token(T_OUT, 7'd5, 4'd0, 1'b0);
        send_data(1'b0, 1, 1'b0, wr);
        checks++; if (bus.data_commit !== 1'b1) begin errors++; $display("FAIL rst_out_tgl: got %b want 1", bus.data_commit); end
        tx_finish();
    endtask

    initial begin
        bus.fa = 7'd5;
        bus.token_valid = 1'b0; bus.token_fadr = '0; bus.token_endp = '0;
        bus.crc5_err = 1'b0; bus.pid_cks_err = 1'b0;
        {bus.pid_OUT, bus.pid_IN, bus.pid_SETUP, bus.pid_PING, bus.pid_SOF, bus.pid_ACK, bus.pid_DATA0, bus.pid_DATA1} = '0;
        bus.rx_data_valid = 1'b0; bus.rx_data_done = 1'b0; bus.crc16_err = 1'b0;
        bus.ep_stall = 1'b0; bus.ep_rdy = 1'b1; bus.tx_done = 1'b0;

        test_reset();
        test_out_toggle();
        test_setup_in();
        test_handshakes();
        test_crc16_nak();
        test_sof();
        test_timeout_rx();
        test_timeout_ack();
        test_reset_mid_tx();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
